// File: rtl/dev_bus_master.sv
// Command-FIFO bus master: queues commands and runs them one at a time on a strobe/data_ready
// device port. Define DEV_BUS_MASTER_TIMEOUT_EN to enable the WAIT-state timeout.
module dev_bus_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic                    cmd_rw_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_be_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_err_o,
    output logic                    M_DEVICE_strobe_o,
    output logic [ADDR_WIDTH-1:0]   M_DEVICE_addr_o,
    output logic                    M_DEVICE_rw_o,
    output logic [DATA_WIDTH/8-1:0] M_DEVICE_byte_enable_o,
    output logic [DATA_WIDTH-1:0]   M_DEVICE_data_o,
    input  logic                    M_DEVICE_data_ready_i,
    input  logic [DATA_WIDTH-1:0]   M_DEVICE_data_i,
    output logic                    busy_o
);
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned PTR_WIDTH = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_WIDTH = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ENT_WIDTH = ADDR_WIDTH + 1 + BE_WIDTH + DATA_WIDTH;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2)
    begin : g_param_check
        $error("dev_bus_master: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;

    logic [ENT_WIDTH-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]    r_wr_ptr;
    logic [PTR_WIDTH-1:0]    r_rd_ptr;
    logic [CNT_WIDTH-1:0]    r_count;

    logic [ADDR_WIDTH-1:0]   r_dev_addr;
    logic                    r_dev_rw;
    logic [BE_WIDTH-1:0]     r_dev_be;
    logic [DATA_WIDTH-1:0]   r_dev_data;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;

    logic                    w_push;
    logic                    w_pop;
    logic                    w_done;
    logic                    w_tmo_hit;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [ADDR_WIDTH-1:0]   w_head_addr;
    logic                    w_head_rw;
    logic [BE_WIDTH-1:0]     w_head_be;
    logic [DATA_WIDTH-1:0]   w_head_data;

    assign w_fifo_full  = (r_count == CNT_WIDTH'(FIFO_DEPTH));
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = cmd_valid_i && !w_fifo_full;
    assign {w_head_addr, w_head_rw, w_head_be, w_head_data} = r_mem[r_rd_ptr];

    // Command storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_addr_i, cmd_rw_i, cmd_be_i, cmd_wdata_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

`ifdef DEV_BUS_MASTER_TIMEOUT_EN
    localparam int unsigned TMO_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMO_WIDTH-1:0] TMO_MAX = TMO_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [TMO_WIDTH-1:0] r_tmo_cnt;
    logic                 r_rsp_err;

    // Counts WAIT cycles; never exceeds TMO_MAX because WAIT is left on that cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StIssue) begin
            r_tmo_cnt <= '0;
        end else if (r_state == StWait) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_tmo_hit = (r_state == StWait) && (r_tmo_cnt == TMO_MAX);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rsp_err <= 1'b0;
        end else if (w_done) begin
            r_rsp_err <= !M_DEVICE_data_ready_i;
        end
    end

    assign rsp_err_o = r_rsp_err;
`else
    assign w_tmo_hit = 1'b0;
    assign rsp_err_o = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = StIssue;
                end
            end
            StIssue: begin
                w_state_next = StWait;
            end
            StWait: begin
                // Ready takes priority over a coincident timeout.
                if (M_DEVICE_data_ready_i || w_tmo_hit) begin
                    w_done       = 1'b1;
                    w_state_next = StResp;
                end
            end
            StResp: begin
                if (rsp_ready_i) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_dev_addr  <= '0;
            r_dev_rw    <= 1'b0;
            r_dev_be    <= '0;
            r_dev_data  <= '0;
            r_rsp_rdata <= '0;
        end else begin
            if (w_pop) begin
                r_dev_addr <= w_head_addr;
                r_dev_rw   <= w_head_rw;
                r_dev_be   <= w_head_be;
                r_dev_data <= w_head_data;
            end
            if (w_done) begin
                // Writes and timeouts (done without ready) return zero data.
                r_rsp_rdata <= (r_dev_rw || !M_DEVICE_data_ready_i) ? '0 : M_DEVICE_data_i;
            end
        end
    end

    assign cmd_ready_o            = !w_fifo_full;
    assign rsp_valid_o            = (r_state == StResp);
    assign rsp_rdata_o            = r_rsp_rdata;
    assign M_DEVICE_strobe_o      = (r_state == StIssue);
    assign M_DEVICE_addr_o        = r_dev_addr;
    assign M_DEVICE_rw_o          = r_dev_rw;
    assign M_DEVICE_byte_enable_o = r_dev_be;
    assign M_DEVICE_data_o        = r_dev_data;
    assign busy_o                 = (r_state != StIdle) || !w_fifo_empty;

endmodule

// File: doc/dev_bus_master.md
DEV_BUS_MASTER -- requirements
Module: dev_bus_master

Interface
REQ-001 ADDR_WIDTH, 32, device address width.
REQ-002 DATA_WIDTH, 32, device data width.
REQ-003 FIFO_DEPTH, 4, command FIFO entries; power of 2, >=2.
REQ-004 TIMEOUT_CYCLES, 256, max WAIT cycles before timeout; >=2.
REQ-005 clk_i  in  1  sole clock; all state updates on rising edge.
REQ-006 rst_i  in  1  reset; synchronous, active-high.
REQ-007 cmd_valid_i  in  1  command offered.
REQ-008 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-009 cmd_addr_i  in  ADDR_WIDTH  target address.
REQ-010 cmd_rw_i  in  1  1=write, 0=read.
REQ-011 cmd_be_i  in  DATA_WIDTH/8  byte enables.
REQ-012 cmd_wdata_i  in  DATA_WIDTH  write data.
REQ-013 rsp_valid_o  out  1  response available.
REQ-014 rsp_ready_i  in  1  response consumed when high with rsp_valid_o.
REQ-015 rsp_rdata_o  out  DATA_WIDTH  read data; 0 for writes and timeouts.
REQ-016 rsp_err_o  out  1  1=timeout.
REQ-017 M_DEVICE_strobe_o  out  1  one-cycle request pulse.
REQ-018 M_DEVICE_addr_o / M_DEVICE_rw_o / M_DEVICE_byte_enable_o / M_DEVICE_data_o  out  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  request fields.
REQ-019 M_DEVICE_data_ready_i  in  1  responder completion pulse.
REQ-020 M_DEVICE_data_i  in  DATA_WIDTH  responder read data, valid with data_ready.
REQ-021 busy_o  out  1  FSM not IDLE or FIFO non-empty.

Function
REQ-022 cmd_ready_o SHALL equal FIFO not full (registered count); no bypass; push when full never occurs.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH; simultaneous push/pop leaves count unchanged.
REQ-024 FSM states IDLE, ISSUE, WAIT, RESP; one outstanding device transaction.
REQ-025 IDLE: FIFO non-empty -> pop head into holding regs, go ISSUE; else stay.
REQ-026 ISSUE: strobe high exactly one cycle, M_DEVICE_* fields = holding regs -> WAIT.
REQ-027 Latency: command accepted at edge k into empty FIFO with FSM IDLE -> strobe high in cycle k+2.
REQ-028 M_DEVICE_addr/rw/byte_enable/data SHALL stay stable from ISSUE through WAIT and hold last values in IDLE/RESP; strobe low outside ISSUE.
REQ-029 WAIT: data_ready_i high -> capture data_i (reads) or 0 (writes), err=0, go RESP.
REQ-030 data_ready_i SHALL be ignored outside WAIT, including the ISSUE cycle.
REQ-031 Timeout: counter cleared entering WAIT, +1 per WAIT cycle; WAIT cycle with count==TIMEOUT_CYCLES-1 and no ready -> RESP with err=1, rdata=0.
REQ-032 Ready and timeout in same cycle: ready wins, err=0.
REQ-033 RESP: rsp_valid_o high, rsp_rdata_o/rsp_err_o stable until rsp_ready_i; handshake -> IDLE; rsp_valid_o low next cycle.
REQ-034 Commands SHALL keep being accepted while FSM busy, up to FIFO_DEPTH queued plus one in flight.

Reset
REQ-035 rst_i high at an edge: FSM IDLE, FIFO empty, timeout counter 0, all outputs 0 except cmd_ready_o=1 from the first cycle after reset deassertion.
REQ-036 Reset mid-transaction SHALL abandon the in-flight and queued commands with no response; late data_ready_i after reset ignored.

Configuration
REQ-037 Macro DEV_BUS_MASTER_TIMEOUT_EN defined: REQ-031/REQ-032 timeout logic present.
REQ-038 Undefined: no counter, WAIT lasts until data_ready_i indefinitely, rsp_err_o tied 0, TIMEOUT_CYCLES unused.

Verification
REQ-039 Write addr 0xC000_0000, data 0x0000_0041, be 4'b0001; ready 3 cycles after strobe -> one strobe pulse, rw=1, rsp_valid with rdata=0, err=0.
REQ-040 Read addr 0xC000_0004; responder returns 0x0000_0001 with ready -> rsp_rdata_o=0x0000_0001, err=0.
REQ-041 Responder silent, TIMEOUT_EN defined, TIMEOUT_CYCLES=16; strobe in cycle s -> rsp_valid_o high in cycle s+17, err=1, rdata=0.
REQ-042 Responder stalled, 6 back-to-back commands -> 5 accepted (1 in flight + 4 queued), cmd_ready_o low on 6th until first completes.
REQ-043 rsp_ready_i held low 10 cycles -> response fields stable, no new strobe; after handshake next queued strobe in 2 cycles.
REQ-044 rst_i pulsed during WAIT, then data_ready_i -> all outputs 0, no rsp_valid_o, busy_o=0.
